// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display scanner: snapshots a packed value once per frame,
// walks the digits with a dark guard interval before each one, and drives a
// single shared 7-segment decoder plus one-hot digit enables. Leading-zero
// suppression blanks high-order zero digits (digit 0 is always shown).
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dot_mask,
   input  logic                    lz_blank,
   output logic [3:0]              hex_out,
   output logic                    dot_out,
   output logic [NUM_DIGITS-1:0]   digit_an,
   output logic                    blank,
   output logic                    frame_tick
);

   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GUARD = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [IW-1:0]           idx_reg, idx_next;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic [4*NUM_DIGITS-1:0] snap_val_reg, snap_val_next;
   logic [NUM_DIGITS-1:0]   snap_dot_reg, snap_dot_next;
   logic                    snap_lz_reg, snap_lz_next;
   logic                    frame_start;

   logic [3:0]              hex_reg, hex_next;
   logic                    dot_reg, dot_next;
   logic [NUM_DIGITS-1:0]   an_reg, an_next;
   logic                    blank_reg, blank_next;
   logic                    tick_reg;

   // Per-digit suppression flags, derived from the snapshot that will be in
   // effect after the coming edge so the registered outputs line up with it.
   logic [NUM_DIGITS-1:0]   upper_zero;
   logic [NUM_DIGITS-1:0]   suppress_vec;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_supp
         assign upper_zero[gi] = ((snap_val_next >> (4 * gi)) == '0);
         if (gi == 0) begin : g_first
            assign suppress_vec[gi] = 1'b0;
         end else begin : g_upper
            assign suppress_vec[gi] = snap_lz_next & upper_zero[gi];
         end
      end
   endgenerate

   // Next-state logic: guard/show dwell counting, digit stepping and frame snapshot.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      cnt_next      = cnt_reg;
      snap_val_next = snap_val_reg;
      snap_dot_next = snap_dot_reg;
      snap_lz_next  = snap_lz_reg;
      frame_start   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (en) begin
               state_next    = GUARD;
               idx_next      = '0;
               cnt_next      = '0;
               snap_val_next = value;
               snap_dot_next = dot_mask;
               snap_lz_next  = lz_blank;
               frame_start   = 1'b1;
            end
         end
         GUARD: begin
            if (!en) begin
               state_next = IDLE;
               idx_next   = '0;
               cnt_next   = '0;
            end else if (cnt_reg == GUARD_LAST) begin
               state_next = SHOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SHOW: begin
            if (!en) begin
               state_next = IDLE;
               idx_next   = '0;
               cnt_next   = '0;
            end else if (cnt_reg == SHOW_LAST) begin
               state_next = GUARD;
               cnt_next   = '0;
               if (idx_reg == LAST_IDX) begin
                  idx_next      = '0;
                  snap_val_next = value;
                  snap_dot_next = dot_mask;
                  snap_lz_next  = lz_blank;
                  frame_start   = 1'b1;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
         end
      endcase
   end

   // Output decode for the coming cycle: nibble/dot of the selected digit and its enable.
   always_comb begin
      logic [3:0] nib;
      logic       dot_bit;
      logic       supp;
      logic       lit;

      nib     = 4'h0;
      dot_bit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_next == IW'(i)) begin
            nib     = snap_val_next[4*i +: 4];
            dot_bit = snap_dot_next[i];
         end
      end
      supp = suppress_vec[idx_next];
      lit  = (state_next == SHOW) && !supp;

      hex_next   = (state_next == IDLE) ? 4'h0 : nib;
      dot_next   = (state_next == IDLE) ? 1'b0 : (dot_bit & ~supp);
      an_next    = lit ? (NUM_DIGITS'(1) << idx_next) : '0;
      blank_next = !lit;
   end

   // State, snapshot and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         cnt_reg      <= '0;
         snap_val_reg <= '0;
         snap_dot_reg <= '0;
         snap_lz_reg  <= 1'b0;
         hex_reg      <= 4'h0;
         dot_reg      <= 1'b0;
         an_reg       <= '0;
         blank_reg    <= 1'b1;
         tick_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         cnt_reg      <= cnt_next;
         snap_val_reg <= snap_val_next;
         snap_dot_reg <= snap_dot_next;
         snap_lz_reg  <= snap_lz_next;
         hex_reg      <= hex_next;
         dot_reg      <= dot_next;
         an_reg       <= an_next;
         blank_reg    <= blank_next;
         tick_reg     <= frame_start;
      end
   end

   assign hex_out    = hex_reg;
   assign dot_out    = dot_reg;
   assign digit_an   = an_reg;
   assign blank      = blank_reg;
   assign frame_tick = tick_reg;

endmodule
